// File: rtl/plugboard_config.sv
// Plugboard configuration controller: CONNECT / DISCONNECT / CLEAR commands maintain a
// reciprocal 26-entry letter map. Define PLUGCFG_PAIR_LIMIT_EN to enforce the 10-cable limit.
module plugboard_config (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [4:0]   cmd_a,
    input  logic [4:0]   cmd_b,
    input  logic         cfg_lock,
    output logic         rsp_valid,
    output logic [2:0]   rsp_code,
    output logic [129:0] plug_map,
    output logic [3:0]   pair_count,
    output logic         map_stable
);
    localparam int unsigned N_LETTERS = 26;
    localparam int unsigned LW        = 5;
    localparam int unsigned CW        = 3;
    localparam int unsigned PW        = 4;

    localparam logic [1:0] OP_CLEAR      = 2'b00;
    localparam logic [1:0] OP_CONNECT    = 2'b01;
    localparam logic [1:0] OP_DISCONNECT = 2'b10;
    localparam logic [1:0] OP_RESERVED   = 2'b11;

    localparam logic [CW-1:0] RC_OK         = 3'd0;
    localparam logic [CW-1:0] RC_BAD_LETTER = 3'd1;
    localparam logic [CW-1:0] RC_SAME       = 3'd2;
    localparam logic [CW-1:0] RC_IN_USE     = 3'd3;
    localparam logic [CW-1:0] RC_NOT_PAIRED = 3'd4;
    localparam logic [CW-1:0] RC_LIMIT      = 3'd5;
    localparam logic [CW-1:0] RC_LOCKED     = 3'd6;
    localparam logic [CW-1:0] RC_BAD_OP     = 3'd7;

    localparam logic [LW-1:0] LAST_LETTER = LW'(N_LETTERS - 1);

    typedef enum logic [2:0] {
        IDLE, CHECK, WRITE_A, WRITE_B, CLEAR, RESP
    } state_t;

    state_t        state, next_state;
    logic [1:0]    op_q;
    logic [LW-1:0] a_q, b_q;
    logic [CW-1:0] code_q, chk_code;
    logic [LW-1:0] clr_idx;
    logic [LW-1:0] map_q [N_LETTERS];
    logic [LW-1:0] map_a, map_b;
    logic          a_ok, b_ok, limit_hit;

    // Flat view of the map: entry i in bits [5i+4:5i]
    for (genvar gi = 0; gi < N_LETTERS; gi++) begin : g_pack
        assign plug_map[gi*LW +: LW] = map_q[gi];
    end

`ifdef PLUGCFG_PAIR_LIMIT_EN
    assign limit_hit = (pair_count == PW'(10));
`else
    assign limit_hit = 1'b0;
`endif

    assign a_ok  = (a_q <= LAST_LETTER);
    assign b_ok  = (b_q <= LAST_LETTER);
    assign map_a = a_ok ? map_q[a_q] : a_q;
    assign map_b = b_ok ? map_q[b_q] : b_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic and prioritised command check
    always_comb begin
        next_state = state;
        chk_code   = RC_OK;

        if (cfg_lock)                        chk_code = RC_LOCKED;
        else if (op_q == OP_CLEAR)           chk_code = RC_OK;
        else if (op_q == OP_RESERVED)        chk_code = RC_BAD_OP;
        else if (!a_ok || !b_ok)             chk_code = RC_BAD_LETTER;
        else if (a_q == b_q)                 chk_code = RC_SAME;
        else if (op_q == OP_CONNECT && limit_hit)
                                             chk_code = RC_LIMIT;
        else if (op_q == OP_CONNECT && (map_a != a_q || map_b != b_q))
                                             chk_code = RC_IN_USE;
        else if (op_q == OP_DISCONNECT && map_a != b_q)
                                             chk_code = RC_NOT_PAIRED;

        case (state)
            IDLE:    if (cmd_valid && cmd_ready) next_state = CHECK;
            CHECK: begin
                if (chk_code != RC_OK)       next_state = RESP;
                else if (op_q == OP_CLEAR)   next_state = CLEAR;
                else                         next_state = WRITE_A;
            end
            WRITE_A: next_state = WRITE_B;
            WRITE_B: next_state = RESP;
            CLEAR:   if (clr_idx == LAST_LETTER) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: command capture, map writes and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OP_CLEAR;
            a_q        <= '0;
            b_q        <= '0;
            code_q     <= RC_OK;
            clr_idx    <= '0;
            pair_count <= '0;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_code   <= RC_OK;
            map_stable <= 1'b1;
            for (int i = 0; i < N_LETTERS; i++) map_q[i] <= LW'(i);
        end else begin
            cmd_ready  <= (next_state == IDLE);
            rsp_valid  <= (state == RESP);
            map_stable <= !(next_state == WRITE_A || next_state == WRITE_B ||
                            next_state == CLEAR);
            if (state == RESP) rsp_code <= code_q;

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q <= cmd_op;
                        a_q  <= cmd_a;
                        b_q  <= cmd_b;
                    end
                end
                CHECK: begin
                    code_q  <= chk_code;
                    clr_idx <= '0;
                end
                WRITE_A: map_q[a_q] <= (op_q == OP_CONNECT) ? b_q : a_q;
                WRITE_B: begin
                    map_q[b_q] <= (op_q == OP_CONNECT) ? a_q : b_q;
                    if (op_q == OP_CONNECT) pair_count <= pair_count + PW'(1);
                    else                    pair_count <= pair_count - PW'(1);
                end
                CLEAR: begin
                    map_q[clr_idx] <= clr_idx;
                    clr_idx        <= clr_idx + LW'(1);
                    if (clr_idx == LAST_LETTER) pair_count <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_plugboard_config.sv
// Scoreboard bench for plugboard_config: driver pushes model-predicted responses,
// monitor pops and compares on every rsp_valid.
module tb_plugboard_config;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [4:0]   cmd_a, cmd_b;
    logic         cfg_lock;
    logic         rsp_valid;
    logic [2:0]   rsp_code;
    logic [129:0] plug_map;
    logic [3:0]   pair_count;
    logic         map_stable;

    plugboard_config dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cfg_lock(cfg_lock),
        .rsp_valid(rsp_valid), .rsp_code(rsp_code), .plug_map(plug_map),
        .pair_count(pair_count), .map_stable(map_stable)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   code;
        logic [129:0] map;
        logic [3:0]   cnt;
        int           lat;
        int           unst;
        int           t;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   unst = 0;
    int   rsp_seen = 0;
    int   part[26];
    int   cnt;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [129:0] act, input logic [129:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [129:0] model_map();
        logic [129:0] m;
        for (int i = 0; i < 26; i++) m[i*5 +: 5] = 5'(part[i]);
        return m;
    endfunction

    function automatic logic [129:0] identity_map();
        logic [129:0] m;
        for (int i = 0; i < 26; i++) m[i*5 +: 5] = 5'(i);
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 26; i++) part[i] = i;
        cnt = 0;
    endtask

    // Response code from the command rules, in priority order
    function automatic logic [2:0] model_code(input int op, input int a, input int b, input bit lock);
        bit lim;
`ifdef PLUGCFG_PAIR_LIMIT_EN
        lim = (cnt == 10);
`else
        lim = 1'b0;
`endif
        if (lock) return 3'd6;
        if (op == 0) return 3'd0;
        if (op == 3) return 3'd7;
        if (a > 25 || b > 25) return 3'd1;
        if (a == b) return 3'd2;
        if (op == 1 && lim) return 3'd5;
        if (op == 1 && (part[a] != a || part[b] != b)) return 3'd3;
        if (op == 2 && part[a] != b) return 3'd4;
        return 3'd0;
    endfunction

    // Monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            unst = 0;
        end else begin
            if (!map_stable) unst++;
            if (rsp_valid) begin
                exp_t e;
                rsp_seen++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got code %0d expected no response", rsp_code);
                end else begin
                    e = q.pop_front();
                    chk("rsp_code",   130'(rsp_code),   130'(e.code));
                    chk("plug_map",   plug_map,         e.map);
                    chk("pair_count", 130'(pair_count), 130'(e.cnt));
                    chk("latency",    130'(cyc - e.t),  130'(e.lat));
                    chk("unstable_cycles", 130'(unst),  130'(e.unst));
                end
                unst = 0;
            end
        end
    end

    task automatic issue(input int op, input int a, input int b, input bit lock, input bit wait_rsp);
        exp_t e;
        int   n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            chk("ready_timeout", 130'(cmd_ready), 130'(1));
            return;
        end
        e.code = model_code(op, a, b, lock);
        e.lat  = (e.code != 0) ? 2 : (op == 0) ? 28 : 4;
        e.unst = (e.code != 0) ? 0 : (op == 0) ? 26 : 2;
        if (e.code == 0) begin
            if (op == 0) model_reset();
            else if (op == 1) begin part[a] = b; part[b] = a; cnt++; end
            else begin part[a] = a; part[b] = b; cnt--; end
        end
        e.map = model_map();
        e.cnt = 4'(cnt);
        cmd_op    = 2'(op);
        cmd_a     = 5'(a);
        cmd_b     = 5'(b);
        cfg_lock  = lock;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        e.t = cyc;
        q.push_back(e);
        cmd_valid = 1'b0;
        if (wait_rsp) begin
            n = 0;
            while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
            if (q.size() != 0) begin
                chk("rsp_timeout", 130'(q.size()), 130'(0));
                q.delete();
            end
            cfg_lock = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_map",        plug_map,         identity_map());
        chk("rst_pair_count", 130'(pair_count), 130'(0));
        chk("rst_rsp_valid",  130'(rsp_valid),  130'(0));
        chk("rst_rsp_code",   130'(rsp_code),   130'(0));
        chk("rst_map_stable", 130'(map_stable), 130'(1));
        chk("rst_cmd_ready",  130'(cmd_ready),  130'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 130'(cmd_ready), 130'(1));
        @(negedge clk);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cfg_lock = 1'b0;
        model_reset();
        do_reset();

        issue(1, 0, 1, 0, 1);
        issue(1, 0, 2, 0, 1);
        issue(1, 3, 3, 0, 1);
        issue(1, 26, 4, 0, 1);
        issue(3, 5, 6, 0, 1);
        issue(1, 0, 1, 0, 1);
        issue(2, 1, 0, 0, 1);
        issue(2, 1, 0, 0, 1);
        issue(2, 7, 7, 0, 1);

        do_reset();
        for (int i = 0; i < 10; i++) issue(1, 2*i, 2*i+1, 0, 1);
        issue(1, 20, 21, 0, 1);
        issue(0, 0, 0, 1, 1);
        issue(0, 0, 0, 0, 1);
        issue(1, 4, 9, 1, 1);

        // Reset landing in the middle of a CLEAR sweep
        issue(1, 5, 9, 0, 1);
        issue(1, 11, 12, 0, 1);
        issue(0, 0, 0, 0, 0);
        seen = rsp_seen;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        model_reset();
        #1;
        chk("midclear_map",   plug_map,         identity_map());
        chk("midclear_count", 130'(pair_count), 130'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midclear_ready", 130'(cmd_ready), 130'(1));
        repeat (30) @(negedge clk);
        chk("midclear_no_rsp", 130'(rsp_seen - seen), 130'(0));

        for (int k = 0; k < 400; k++) begin
            int r, op, a, b;
            bit lock;
            r = $urandom_range(0, 99);
            op = (r < 4) ? 0 : (r < 8) ? 3 : (r < 58) ? 1 : 2;
            a = ($urandom_range(0, 19) == 0) ? $urandom_range(26, 31) : $urandom_range(0, 25);
            b = ($urandom_range(0, 19) == 0) ? $urandom_range(26, 31) : $urandom_range(0, 25);
            if (op == 2 && a <= 25 && $urandom_range(0, 9) < 7) b = part[a];
            lock = ($urandom_range(0, 19) == 0);
            issue(op, a, b, lock, 1);
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", 130'(q.size()), 130'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
